// File: rtl/perf_cntr_unit.sv
// Performance counters: one enabled-cycle channel plus NUM_EVT event channels behind a small MMIO port.
// Reads return data one cycle after req_i and never stall; writes take effect at the end of the request cycle.
module perf_cntr_unit #(
  parameter int NUM_EVT = 4,
  parameter int CNTR_W  = 64,
  parameter bit AUTO_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               halt_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam int NCH = NUM_EVT + 1;

  // Channel 0 is the cycle counter; channel i+1 is event i.
  logic [NCH-1:0][CNTR_W-1:0] cnt;
  logic                       enable;
  logic [31:0]                shadow;
  logic [NCH-1:0]             inc;
  logic [NCH-1:0]             wrap;
  logic [NCH-1:0]             w1c;
  logic                       run;
  logic                       clr;
  logic                       wr_ctrl;
  logic                       wr_stat;
  logic                       rd;
  logic                       is_cnt;
  logic                       lo_rd;
  logic [5:0]                 widx;
  logic [5:0]                 coff;
  logic [63:0]                sel;
  logic [31:0]                rd_val;
  logic                       unused_bits;

  assign widx    = addr_i[7:2];
  assign coff    = widx - 6'd2;
  assign run     = enable && !halt_i;
  assign inc     = {evt_i, 1'b1} & {NCH{run}};
  assign wr_ctrl = req_i && we_i && (widx == 6'd0);
  assign wr_stat = req_i && we_i && (widx == 6'd1);
  assign clr     = wr_ctrl && wdata_i[1];
  assign w1c     = wr_stat ? wdata_i[NUM_EVT:0] : '0;
  assign rd      = req_i && !we_i;
  assign lo_rd   = rd && is_cnt && !widx[0];

  assign unused_bits = ^{addr_i[1:0], wdata_i};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wrap[k] = inc[k] && (&cnt[k]);
    end
  end

  // Zero-extending to 64 bits makes the hi half read as 0 when CNTR_W is 32.
  always_comb begin
    sel    = '0;
    is_cnt = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if ((widx >= 6'd2) && (coff[5:1] == 5'(k))) begin
        sel    = 64'(cnt[k]);
        is_cnt = 1'b1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (widx == 6'd0) begin
      rd_val = {31'b0, enable};
    end else if (widx == 6'd1) begin
      rd_val = 32'(ovf_o);
    end else if (is_cnt) begin
      rd_val = widx[0] ? shadow : sel[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      enable   <= AUTO_EN;
      cnt      <= '0;
      ovf_o    <= '0;
      shadow   <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd;
      if (rd) begin
        rdata_o <= rd_val;
      end
      if (lo_rd) begin
        shadow <= sel[63:32];
      end
      if (wr_ctrl) begin
        enable <= wdata_i[0];
      end
      for (int k = 0; k < NCH; k++) begin
        if (clr) begin
          cnt[k] <= '0;
        end else if (inc[k]) begin
          cnt[k] <= cnt[k] + CNTR_W'(1);
        end
      end
      // A fresh wrap beats a simultaneous W1C; clear beats everything.
      ovf_o <= clr ? '0 : ((ovf_o & ~w1c) | wrap);
    end
  end

endmodule

// File: tb/tb_perf_cntr_unit.sv
// Directed bench for perf_cntr_unit (NUM_EVT=4, CNTR_W=64, AUTO_EN=1).
module tb_perf_cntr_unit;

  localparam int NUM_EVT = 4;
  localparam int CNTR_W  = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_EVT-1:0] evt;
  logic               halt;
  logic               req;
  logic               we;
  logic [7:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               rvalid;
  logic [NUM_EVT:0]   ovf;
  logic [NUM_EVT:0][CNTR_W-1:0] preset;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  perf_cntr_unit #(.NUM_EVT(NUM_EVT), .CNTR_W(CNTR_W), .AUTO_EN(1'b1)) dut (
    .clk_i   (clk),
    .rst_n   (rst_n),
    .evt_i   (evt),
    .halt_i  (halt),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .rvalid_o(rvalid),
    .ovf_o   (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one read and checks the response one cycle later.
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    @(negedge clk);
    req = 1'b0;
    check({tag, "/vld"}, 64'(rvalid), 64'd1);
    check(tag, 64'(rdata), 64'(exp));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    req   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; req = 1'b0; we = 1'b0;
    evt = '0; addr = '0; wdata = '0; preset = '0;
    repeat (2) @(negedge clk);
    check("rst/vld", 64'(rvalid), 64'd0);
    check("rst/dat", 64'(rdata), 64'd0);
    check("rst/ovf", 64'(ovf), 64'd0);

    // Free-running cycle count out of reset.
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk("cyc100", 8'h08, 32'd100);
    @(negedge clk);
    check("hold/vld", 64'(rvalid), 64'd0);
    check("hold/dat", 64'(rdata), 64'd100);
    rd_chk("cyc_hi", 8'h0C, 32'd0);
    for (int a = 16; a < 48; a += 4) rd_chk("evt_zero", 8'(a), 32'd0);

    // 37 event-2 pulses, 10 of them under halt.
    wr(8'h00, 32'h3);
    for (int i = 0; i < 37; i++) begin
      evt  = 4'b0100;
      halt = (i >= 10) && (i < 20);
      @(negedge clk);
    end
    evt = '0; halt = 1'b0;
    rd_chk("evt2_lo", 8'h20, 32'd27);
    rd_chk("cyc_halt", 8'h08, 32'd28);

    // Clear coinciding with all events high.
    evt = '1;
    wr(8'h00, 32'h3);
    evt = '0;
    check("clr/ovf", 64'(ovf), 64'd0);
    rd_chk("clr/cyc0", 8'h08, 32'd0);
    rd_chk("clr/cyc1", 8'h08, 32'd1);
    rd_chk("clr/evt0", 8'h10, 32'd0);
    rd_chk("clr/evt3", 8'h28, 32'd0);

    // Preload near the carry / wrap points while halted.
    halt = 1'b1;
    @(negedge clk);
    preset[0] = 64'h0000_0001_FFFF_FFFF;
    preset[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut.cnt = preset;
    #1;
    release dut.cnt;
    halt = 1'b0;
    req = 1'b1; we = 1'b0; addr = 8'h08;
    @(negedge clk);
    check("coh/lo_vld", 64'(rvalid), 64'd1);
    check("coh/lo", 64'(rdata), 64'hFFFF_FFFF);
    addr = 8'h0C;
    @(negedge clk);
    req = 1'b0;
    check("coh/hi_vld", 64'(rvalid), 64'd1);
    check("coh/hi", 64'(rdata), 64'd1);
    rd_chk("coh/lo2", 8'h08, 32'd1);
    rd_chk("coh/hi2", 8'h0C, 32'd2);

    evt = 4'b0010;
    @(negedge clk);
    check("ovf/none", 64'(ovf), 64'd0);
    @(negedge clk);
    evt = '0;
    check("ovf/set", 64'(ovf), 64'h4);
    rd_chk("ovf/lo", 8'h18, 32'd0);
    rd_chk("ovf/hi", 8'h1C, 32'd0);
    rd_chk("status", 8'h04, 32'h4);
    wr(8'h04, 32'h1);
    check("w1c_other", 64'(ovf), 64'h4);
    wr(8'h04, 32'h4);
    check("w1c", 64'(ovf), 64'd0);

    // Disabled counting, ignored counter writes, unmapped read.
    wr(8'h00, 32'h3);
    wr(8'h00, 32'h0);
    evt = '1;
    rd_chk("frz/ctrl", 8'h00, 32'd0);
    wr(8'h08, 32'h55);
    rd_chk("frz/evt", 8'h10, 32'd0);
    rd_chk("frz/cyc", 8'h08, 32'd1);
    evt = '0;
    rd_chk("unmapped", 8'hFC, 32'd0);
    rd_chk("frz/cyc2", 8'h08, 32'd1);

    // Reset arriving with a read in flight.
    req = 1'b1; we = 1'b0; addr = 8'h08; rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b1;
    check("rstrd/vld", 64'(rvalid), 64'd0);
    check("rstrd/dat", 64'(rdata), 64'd0);
    rd_chk("rst/ctrl", 8'h00, 32'd1);
    rd_chk("rst/cyc", 8'h08, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_cntr_unit.md
# perf_cntr_unit

Synthesisable, parametrised hardware performance-counter block for the SoC, replacing testbench-only cycle/retire/branch counting. It counts a free-running enabled-cycle channel plus NUM_EVT per-cycle event channels (retire, control transfer, mispredict, stall, …) driven by the CPU. It exposes them through a simple single-cycle-latency register port with coherent 64-bit reads, software enable/clear, and sticky overflow flags. It sits beside the CPU in `main` on the local MMIO bus.

## Interface
Parameters:
- NUM_EVT, 4, number of event channels, legal 1..16
- CNTR_W, 64, counter width, legal 32 or 64
- AUTO_EN, 1, reset value of CTRL.enable (1 = counting starts out of reset)

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- evt_i  in  NUM_EVT  event pulses, bit i counts channel i once per cycle high
- halt_i  in  1  level; freezes all counting while high (simulation-finish / debug halt)
- req_i  in  1  register access strobe, one access per cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  8  byte address, word aligned; addr_i[1:0] ignored
- wdata_i  in  32  write data
- rdata_o  out  32  read data
- rvalid_o  out  1  read data valid
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle channel, bit i+1 = event i

## Operation
Register map:
- 0x00 CTRL: bit0 enable (RW); bit1 clear (W1, self-clearing, reads 0); other bits read 0
- 0x04 STATUS: ovf flags in bits [NUM_EVT:0]; write-1-to-clear per bit
- 0x08/0x0C: cycle counter lo/hi
- 0x10+8*i / 0x14+8*i: event i counter lo/hi
- Counter registers read-only; writes ignored. Unmapped reads return 0 with rvalid_o.

Counting:
- cycle counter += 1 each cycle with enable && !halt_i
- event i counter += 1 each cycle with enable && !halt_i && evt_i[i]
- Counters are CNTR_W bits and wrap to 0 at all-ones. A wrap sets the matching ovf bit, which stays set until a STATUS W1C or a clear.
- Clear zeroes all counters and all ovf bits. Clear wins over an increment and over an ovf set in the same cycle.
- Writing CTRL = 0x3 clears, and counting resumes from 0 on the next cycle.

Coherent read:
- A lo-word read returns counter[31:0] and latches counter[CNTR_W-1:32] into one shared hi-shadow register.
- Any hi-word read returns the hi-shadow, regardless of which lo word was last read.
- CNTR_W=32: hi reads return 0 and the shadow stays 0.
- Hi-shadow resets to 0; clear does not touch it.

## Timing
- Reset (rst_n low at posedge): counters 0, ovf_o 0, hi-shadow 0, rdata_o 0, rvalid_o 0, enable = AUTO_EN.
- Reset mid-operation discards any in-flight read; rvalid_o is 0 in the following cycle.
- Reads:
  - Read request in cycle t samples register values as they stood at the start of cycle t.
  - rdata_o and rvalid_o are valid in cycle t+1 for exactly one cycle.
  - rdata_o holds its last value while rvalid_o is 0.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Writes take effect at the posedge ending the request cycle:
  - a CTRL enable change affects counting from cycle t+1
  - an event in cycle t is included in a read issued in t+1
- STATUS W1C in the same cycle as a new overflow on that bit: the set wins.
- ovf_o is registered and rises the cycle after the wrapping increment.

## Test plan
- Reset, AUTO_EN=1, no events, halt_i=0, 100 cycles, read 0x08 -> rdata_o=100 (±1 per the sampling rule), rvalid_o one cycle after req_i; reads of 0x10..0x2C return 0.
- Pulse evt_i[2] on 37 cycles while halt_i is high for 10 of them -> event-2 lo=27; cycle counter does not advance during halt.
- Event-1 counter preloaded near wrap by forcing CNTR_W=32 and running 2^32-1 events (or force the counter to 0xFFFFFFFE), then 2 more events -> lo=0, ovf_o[2]=1. Write 0x04=0x4 -> ovf_o[2]=0.
- CNTR_W=64, cycle counter at 0x1_FFFFFFFF: read lo then hi in consecutive cycles across the carry -> lo=0xFFFFFFFF, hi=0x1 (shadow coherent, not 0x2).
- Write CTRL=0x3 in the same cycle as evt_i all-ones -> all counters 0 next cycle, ovf_o=0, counting resumes and cycle counter=1 one cycle later.
- Write CTRL=0x0 -> counters frozen; read 0xFC -> 0 with rvalid_o=1; rst_n low mid-read -> rvalid_o=0, enable returns to AUTO_EN.
